// File: rtl/rx_eth_if.sv
// rx_eth_if: bundles the byte stream, payload stream, header fields and status
// pulses of the Ethernet II receiver.
//   slave  : receiver side (takes s_axis_* and local_mac, drives everything else)
//   master : environment side (drives s_axis_* and local_mac, observes results)
// Clock and reset are not part of the bundle; they stay plain ports on rx_eth.
interface rx_eth_if;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic [47:0] local_mac;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic [15:0] eth_type;
  logic        frame_ok;
  logic        frame_err;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, local_mac,
    output m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast,
    output dst_mac, src_mac, eth_type, frame_ok, frame_err
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, local_mac,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast,
    input  dst_mac, src_mac, eth_type, frame_ok, frame_err
  );
endinterface

// File: rtl/rx_eth.sv
// rx_eth: Ethernet II frame receiver on a byte-wide GMII-style stream.
// Strips preamble/SFD, latches dst/src/eth_type, streams the payload as
// AXI-Stream (no back-pressure) and checks the trailing 4-byte FCS.
// Ports:
//   s_axis_aclk  : sole clock
//   reset        : asynchronous, active-high reset
//   bus (slave)  : s_axis_tdata/tvalid in, local_mac in,
//                  m_axis_tdata/tvalid/tuser/tlast out,
//                  dst_mac/src_mac/eth_type out, frame_ok/frame_err pulses out
// Parameters:
//   PREA_MIN  : minimum number of 0x55 bytes before the SFD
//   MAX_FRAME : maximum byte count dst_mac..FCS; longer frames are errors
// Build option:
//   RX_ETH_MAC_FILTER_EN : when defined, frames whose dst_mac is neither
//   local_mac nor broadcast are silently dropped at header completion.
module rx_eth #(
  parameter int PREA_MIN  = 1,
  parameter int MAX_FRAME = 1518
) (
  input logic     s_axis_aclk,
  input logic     reset,
  rx_eth_if.slave bus
);

  localparam logic [7:0]  PREA_MIN_C  = 8'(PREA_MIN);
  localparam logic [10:0] MAX_FRAME_C = 11'(MAX_FRAME);
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREA = 3'd1,
    ST_HEAD = 3'd2,
    ST_DATA = 3'd3,
    ST_FIN  = 3'd4,
    ST_DROP = 3'd5
  } state_t;

  // Reflected CRC-32 (Ethernet polynomial), one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) begin
        c = {1'b0, c[31:1]} ^ CRC_POLY;
      end else begin
        c = {1'b0, c[31:1]};
      end
    end
    return c;
  endfunction

  state_t       state_r, state_n;
  logic [7:0]   prea_cnt_r;
  logic [3:0]   head_cnt_r;
  logic [10:0]  byte_cnt_r;
  logic [2:0]   fill_r;
  logic         ovr_r;
  logic         first_r;
  logic [7:0]   line_r [0:4];  // [0] newest, [4] oldest
  logic [31:0]  crc_r;
  logic [103:0] hdr_sh_r;

  logic [7:0]   m_tdata_r;
  logic         m_tvalid_r, m_tuser_r, m_tlast_r;
  logic [47:0]  dst_mac_r, src_mac_r;
  logic [15:0]  eth_type_r;
  logic         ok_r, err_r;

  logic         vld_s;
  logic [7:0]   din_s;
  logic [111:0] hdr_full_s;
  logic         accept_s;
  logic [31:0]  fcs_s;
  logic         fcs_good_s;

  // Control strobes from the FSM
  logic push_s, emit_s, tlast_s, ok_s, err_s;
  logic hdr_shift_s, hdr_load_s, crc_clr_s, crc_upd_s;
  logic [7:0] crc_byte_s;
  logic prea_set_s, prea_inc_s, frame_start_s, cnt_inc_s, ovr_set_s;

  assign vld_s      = bus.s_axis_tvalid;
  assign din_s      = bus.s_axis_tdata;
  assign hdr_full_s = {hdr_sh_r, din_s};

  // Transmitted FCS is the complemented CRC, low byte first; line[3] holds b0.
  assign fcs_s      = ~crc_r;
  assign fcs_good_s = ({line_r[3], line_r[2], line_r[1], line_r[0]} ==
                       {fcs_s[7:0], fcs_s[15:8], fcs_s[23:16], fcs_s[31:24]});

`ifdef RX_ETH_MAC_FILTER_EN
  assign accept_s = (hdr_full_s[111:64] == bus.local_mac) ||
                    (hdr_full_s[111:64] == 48'hFFFF_FFFF_FFFF);
`else
  logic local_mac_unused_s;
  assign local_mac_unused_s = ^bus.local_mac;
  assign accept_s = 1'b1;
`endif

  // State register
  always_ff @(posedge s_axis_aclk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state decode and per-cycle control strobes
  always_comb begin
    state_n       = state_r;
    push_s        = 1'b0;
    emit_s        = 1'b0;
    tlast_s       = 1'b0;
    ok_s          = 1'b0;
    err_s         = 1'b0;
    hdr_shift_s   = 1'b0;
    hdr_load_s    = 1'b0;
    crc_clr_s     = 1'b0;
    crc_upd_s     = 1'b0;
    crc_byte_s    = 8'h00;
    prea_set_s    = 1'b0;
    prea_inc_s    = 1'b0;
    frame_start_s = 1'b0;
    cnt_inc_s     = 1'b0;
    ovr_set_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        crc_clr_s = 1'b1;
        if (vld_s) begin
          if (din_s == 8'h55) begin
            prea_set_s = 1'b1;
            state_n    = ST_PREA;
          end else begin
            state_n = ST_DROP;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_PREA: begin
        crc_clr_s = 1'b1;
        if (!vld_s) begin
          state_n = ST_IDLE;
        end else if (din_s == 8'h55) begin
          prea_inc_s = 1'b1;
          state_n    = ST_PREA;
        end else if ((din_s == 8'hD5) && (prea_cnt_r >= PREA_MIN_C)) begin
          frame_start_s = 1'b1;
          state_n       = ST_HEAD;
        end else begin
          state_n = ST_DROP;
        end
      end
      ST_HEAD: begin
        if (!vld_s) begin
          err_s   = 1'b1;
          state_n = ST_IDLE;
        end else begin
          hdr_shift_s = 1'b1;
          crc_upd_s   = 1'b1;
          crc_byte_s  = din_s;
          cnt_inc_s   = 1'b1;
          if (head_cnt_r == 4'd13) begin
            if (accept_s) begin
              hdr_load_s = 1'b1;
              state_n    = ST_DATA;
            end else begin
              state_n = ST_DROP;
            end
          end else begin
            state_n = ST_HEAD;
          end
        end
      end
      ST_DATA: begin
        if (!vld_s) begin
          // Frame end: a full line means payload + FCS, otherwise a runt.
          if (fill_r == 3'd5) begin
            emit_s     = 1'b1;
            tlast_s    = 1'b1;
            crc_upd_s  = 1'b1;
            crc_byte_s = line_r[4];
            state_n    = ST_FIN;
          end else begin
            err_s   = 1'b1;
            state_n = ST_IDLE;
          end
        end else if (byte_cnt_r >= MAX_FRAME_C) begin
          // This byte would exceed MAX_FRAME: close the stream here.
          if (fill_r == 3'd5) begin
            emit_s  = 1'b1;
            tlast_s = 1'b1;
          end else begin
            emit_s = 1'b0;
          end
          ovr_set_s = 1'b1;
          state_n   = ST_FIN;
        end else begin
          push_s    = 1'b1;
          cnt_inc_s = 1'b1;
          if (fill_r == 3'd5) begin
            emit_s     = 1'b1;
            crc_upd_s  = 1'b1;
            crc_byte_s = line_r[4];
          end else begin
            emit_s = 1'b0;
          end
          state_n = ST_DATA;
        end
      end
      ST_FIN: begin
        // Status cycle; also behaves like IDLE so back-to-back frames work.
        crc_clr_s = 1'b1;
        if (ovr_r) begin
          err_s   = 1'b1;
          state_n = vld_s ? ST_DROP : ST_IDLE;
        end else begin
          if (fcs_good_s) begin
            ok_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
          if (vld_s) begin
            if (din_s == 8'h55) begin
              prea_set_s = 1'b1;
              state_n    = ST_PREA;
            end else begin
              state_n = ST_DROP;
            end
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (!vld_s) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_DROP;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Preamble counter (saturating)
  always_ff @(posedge s_axis_aclk or posedge reset) begin
    if (reset) begin
      prea_cnt_r <= 8'd0;
    end else if (prea_set_s) begin
      prea_cnt_r <= 8'd1;
    end else if (prea_inc_s && (prea_cnt_r != 8'hFF)) begin
      prea_cnt_r <= prea_cnt_r + 8'd1;
    end
  end

  // Per-frame counters and flags
  always_ff @(posedge s_axis_aclk or posedge reset) begin
    if (reset) begin
      head_cnt_r <= 4'd0;
      byte_cnt_r <= 11'd0;
      fill_r     <= 3'd0;
      ovr_r      <= 1'b0;
      first_r    <= 1'b0;
    end else if (frame_start_s) begin
      head_cnt_r <= 4'd0;
      byte_cnt_r <= 11'd0;
      fill_r     <= 3'd0;
      ovr_r      <= 1'b0;
      first_r    <= 1'b1;
    end else begin
      if (hdr_shift_s) begin
        head_cnt_r <= head_cnt_r + 4'd1;
      end
      if (cnt_inc_s && (byte_cnt_r != 11'h7FF)) begin
        byte_cnt_r <= byte_cnt_r + 11'd1;
      end
      if (push_s && (fill_r != 3'd5)) begin
        fill_r <= fill_r + 3'd1;
      end
      if (ovr_set_s) begin
        ovr_r <= 1'b1;
      end
      if (emit_s) begin
        first_r <= 1'b0;
      end
    end
  end

  // Five-byte delay line holding the FCS candidates
  always_ff @(posedge s_axis_aclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) begin
        line_r[i] <= 8'h00;
      end
    end else if (push_s) begin
      line_r[0] <= din_s;
      for (int i = 1; i < 5; i++) begin
        line_r[i] <= line_r[i-1];
      end
    end
  end

  // Running FCS over dst_mac..last payload byte
  always_ff @(posedge s_axis_aclk or posedge reset) begin
    if (reset) begin
      crc_r <= CRC_INIT;
    end else if (crc_clr_s) begin
      crc_r <= CRC_INIT;
    end else if (crc_upd_s) begin
      crc_r <= crc32_byte(crc_r, crc_byte_s);
    end
  end

  // Header shift register and field latch
  always_ff @(posedge s_axis_aclk or posedge reset) begin
    if (reset) begin
      hdr_sh_r   <= 104'd0;
      dst_mac_r  <= 48'd0;
      src_mac_r  <= 48'd0;
      eth_type_r <= 16'd0;
    end else begin
      if (hdr_shift_s) begin
        hdr_sh_r <= hdr_full_s[103:0];
      end
      if (hdr_load_s) begin
        dst_mac_r  <= hdr_full_s[111:64];
        src_mac_r  <= hdr_full_s[63:16];
        eth_type_r <= hdr_full_s[15:0];
      end
    end
  end

  // Registered payload stream and status pulses
  always_ff @(posedge s_axis_aclk or posedge reset) begin
    if (reset) begin
      m_tdata_r  <= 8'h00;
      m_tvalid_r <= 1'b0;
      m_tuser_r  <= 1'b0;
      m_tlast_r  <= 1'b0;
      ok_r       <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      m_tdata_r  <= emit_s ? line_r[4] : 8'h00;
      m_tvalid_r <= emit_s;
      m_tuser_r  <= emit_s & first_r;
      m_tlast_r  <= tlast_s;
      ok_r       <= ok_s;
      err_r      <= err_s;
    end
  end

  assign bus.m_axis_tdata  = m_tdata_r;
  assign bus.m_axis_tvalid = m_tvalid_r;
  assign bus.m_axis_tuser  = m_tuser_r;
  assign bus.m_axis_tlast  = m_tlast_r;
  assign bus.dst_mac       = dst_mac_r;
  assign bus.src_mac       = src_mac_r;
  assign bus.eth_type      = eth_type_r;
  assign bus.frame_ok      = ok_r;
  assign bus.frame_err     = err_r;

endmodule
